serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial unsigned subtractor: computes diff = a - b - bin, LSB first, one bit per clock.
//  Complements the combinational adder cells. Used where area matters more than latency.
//  Operand and result ports use a valid/ready handshake on each side.
//  SUB_TYPE selects the bit-0 borrow source, the same way ADDER_TYPE selects the adder cell.
// PARAMETERS
//  WIDTH     8  operand/result width in bits, legal range 1..32
//  SUB_TYPE  1  0 = half-subtractor start (bin ignored, treated as 0);
//               1 = full-subtractor start (bin is the initial borrow)
//               any other value: the generate case emits no logic; sim $error at elaboration
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      a/b/bin are valid
//  in_ready   out  1      block can accept an operand set
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow-in (used only when SUB_TYPE=1)
//  out_valid  out  1      diff/bout are valid
//  out_ready  in   1      downstream consumes the result
//  diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//  bout       out  1      1 when a < b + bin (unsigned)
// BEHAVIOUR
//  - Reset (async assert, sync deassert assumed upstream):
//    state=IDLE; diff=0; bout=0; out_valid=0; in_ready=0 while rst_n low.
//  - FSM has 3 states: IDLE -> SHIFT -> DONE -> IDLE.
//    in_ready = (state==IDLE). out_valid = (state==DONE).
//  - IDLE: on a clock edge with in_valid&&in_ready:
//    a_sh<=a; b_sh<=b; borrow<=(SUB_TYPE==1)?bin:0; cnt<=0; state->SHIFT.
//  - SHIFT, every edge:
//    cell(a_sh[0], b_sh[0], borrow) -> d, bo
//    d_sh <= {d, d_sh[WIDTH-1:1]}; borrow <= bo; a_sh, b_sh shift right; cnt++
//    when cnt==WIDTH-1: state->DONE; diff/bout load from the final d_sh/bo.
//  - Latency: out_valid rises after the WIDTH-th edge that follows the accepting edge.
//    Throughput: one operation per WIDTH+2 cycles when out_ready is held at 1.
//  - DONE: diff/bout stay stable until out_valid&&out_ready; on that edge state->IDLE.
//    diff/bout keep their last values after the handshake.
//  - in_valid outside IDLE is ignored; operands are sampled only on the accepting edge.
//  - out_ready outside DONE is ignored. Backpressure may last indefinitely with no loss.
//  - rst_n low in any state aborts at once: partial result discarded, reset values apply.
//  - WIDTH=1: SHIFT lasts exactly one cycle; cnt is 1 bit wide.
//  - cnt width = $clog2(WIDTH) with a minimum of 1.
// STRUCTURE
//  - Package serial_sub_pkg holds:
//    state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
//    the legal SUB_TYPE values SUB_HALF=0, SUB_FULL=1
//  - Sub-module fs_cell: combinational full subtractor.
//    d = a^b^bi; bo = (~a&b) | (~(a^b)&bi)
//    One instance only; the half-subtractor start is the same cell with bi forced to 0 at load.
//  - Top level holds the FSM, counter, shift registers and output registers only.
// TESTING
//  1. WIDTH=8, SUB_TYPE=1: a=8'h5A, b=8'h3C, bin=0
//     -> diff=8'h1E, bout=0, out_valid 8 edges after accept
//  2. a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1
//  3. a=8'h10, b=8'h10, bin=1:
//     SUB_TYPE=1 -> diff=8'hFF, bout=1; SUB_TYPE=0 -> diff=8'h00, bout=0
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1
//     -> diff/bout stable, in_ready=0, new operands not taken; release -> IDLE next edge
//  5. Reset mid-op: assert rst_n=0 after the 3rd SHIFT edge
//     -> out_valid=0, diff=0, in_ready=0 immediately
//     then a=8'hFF, b=8'h01 -> diff=8'hFE, bout=0
//  6. 1000 random ops, WIDTH in {1,8,32}, random in_valid/out_ready gaps
//     -> every result matches a scoreboard model of a-b-bin; no lost or duplicated transfers

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, legal
// SUB_TYPE values, and the counter-width helper.
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int unsigned SUB_HALF = 0;
  localparam int unsigned SUB_FULL = 1;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_e;

  // Bit counter width: clog2(width), never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
//   in_valid/in_ready + a, b, bin : operand side
//   out_valid/out_ready + diff, bout : result side
// master = producer/consumer around the block, slave = the subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
endinterface

// File: rtl/fs_cell.sv
// Combinational one-bit full subtractor: a - b - bi.
//   a_i, b_i, bi_i : operand bits and borrow-in
//   d_c_o          : difference bit
//   bo_c_o         : borrow-out
module fs_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bi_i,
  output logic d_c_o,
  output logic bo_c_o
);

  assign d_c_o  = a_i ^ b_i ^ bi_i;
  assign bo_c_o = (~a_i & b_i) | (~(a_i ^ b_i) & bi_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock:
// diff = (a - b - bin) mod 2^WIDTH, bout = (a < b + bin).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : serial_subtractor_if slave (operand and result handshakes)
// SUB_TYPE: SUB_HALF starts with zero borrow, SUB_FULL starts with bin.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SUB_TYPE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bin_sel;
  logic             cell_d;
  logic             cell_bo;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("serial_subtractor: WIDTH %0d outside 1..32", WIDTH);
  end

  // Initial borrow source chosen at elaboration; an unknown SUB_TYPE builds nothing.
  case (SUB_TYPE)
    SUB_FULL: begin : g_full
      assign bin_sel = bus.bin;
    end
    SUB_HALF: begin : g_half
      logic unused_bin;
      assign unused_bin = bus.bin;
      assign bin_sel    = 1'b0;
    end
    default: begin : g_bad_type
      $error("serial_subtractor: illegal SUB_TYPE %0d", SUB_TYPE);
    end
  endcase

  fs_cell u_cell (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .bi_i   (borrow_q),
    .d_c_o  (cell_d),
    .bo_c_o (cell_bo)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    d_sh_d   = d_sh_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          borrow_d = bin_sel;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // New difference bit enters at the MSB; written as a widened shift so WIDTH=1 works.
        d_sh_d   = WIDTH'({cell_d, d_sh_q} >> 1);
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = cell_bo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d  = d_sh_d;
          bout_d  = cell_bo;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_sh_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      d_sh_q   <= d_sh_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  // in_ready is masked by rst_n so it drops the instant reset asserts.
  assign bus.in_ready  = (state_q == IDLE) & rst_n;
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;

endmodule
